// File: rtl/tdm_demux.sv
// tdm_demux: turns a serial stream of 3-slot TDM frames into three parallel
// registered words. A frame starts on a word flagged with sync. The outputs
// d0..d2 only ever change on a full commit or on reset.
module tdm_demux #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] d0,
   output logic [WIDTH-1:0] d1,
   output logic [WIDTH-1:0] d2,
   output logic             frame_valid,
   output logic             sync_err,
   output logic [1:0]       slot
);

   typedef enum logic {
      IDLE = 1'b0,   // not locked to a frame boundary
      RUN  = 1'b1    // locked; slot_reg tells which slot comes next
   } state_t;

   state_t           state_reg, state_next;
   logic [1:0]       slot_reg, slot_next;
   logic [WIDTH-1:0] shadow0_reg, shadow0_next;
   logic [WIDTH-1:0] shadow1_reg, shadow1_next;
   logic [WIDTH-1:0] d0_reg, d0_next;
   logic [WIDTH-1:0] d1_reg, d1_next;
   logic [WIDTH-1:0] d2_reg, d2_next;
   logic             frame_valid_reg, frame_valid_next;
   logic             sync_err_reg, sync_err_next;

   // State and datapath registers; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         slot_reg        <= 2'd0;
         shadow0_reg     <= '0;
         shadow1_reg     <= '0;
         d0_reg          <= '0;
         d1_reg          <= '0;
         d2_reg          <= '0;
         frame_valid_reg <= 1'b0;
         sync_err_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         slot_reg        <= slot_next;
         shadow0_reg     <= shadow0_next;
         shadow1_reg     <= shadow1_next;
         d0_reg          <= d0_next;
         d1_reg          <= d1_next;
         d2_reg          <= d2_next;
         frame_valid_reg <= frame_valid_next;
         sync_err_reg    <= sync_err_next;
      end
   end

   // Next-state logic: slot capture, frame commit and framing-error detection.
   always_comb begin
      state_next       = state_reg;
      slot_next        = slot_reg;
      shadow0_next     = shadow0_reg;
      shadow1_next     = shadow1_reg;
      d0_next          = d0_reg;
      d1_next          = d1_reg;
      d2_next          = d2_reg;
      frame_valid_next = 1'b0;
      sync_err_next    = 1'b0;

      // A qualifier-low cycle is invisible: everything holds, pulses drop.
      if (en) begin
         case (state_reg)
            IDLE: begin
               // Unsynced words are dropped silently until a sync arrives.
               if (sync) begin
                  shadow0_next = din;
                  slot_next    = 2'd1;
                  state_next   = RUN;
               end
            end
            RUN: begin
               case (slot_reg)
                  2'd0: begin
                     if (sync) begin
                        shadow0_next = din;
                        slot_next    = 2'd1;
                     end else begin
                        // Expected a frame start but got none: lose lock.
                        sync_err_next = 1'b1;
                        slot_next     = 2'd0;
                        state_next    = IDLE;
                     end
                  end
                  2'd1, 2'd2: begin
                     if (sync) begin
                        // Short frame: drop the partial frame and restart
                        // on this word as the new slot 0.
                        sync_err_next = 1'b1;
                        shadow0_next  = din;
                        shadow1_next  = '0;
                        slot_next     = 2'd1;
                     end else if (slot_reg == 2'd1) begin
                        shadow1_next = din;
                        slot_next    = 2'd2;
                     end else begin
                        // Last slot: commit the whole frame at once so the
                        // outputs never show a mix of two frames.
                        d0_next          = shadow0_reg;
                        d1_next          = shadow1_reg;
                        d2_next          = din;
                        frame_valid_next = 1'b1;
                        slot_next        = 2'd0;
                     end
                  end
                  default: begin
                     // Unreachable slot code; fall back to hunting for sync.
                     slot_next  = 2'd0;
                     state_next = IDLE;
                  end
               endcase
            end
            default: begin
               slot_next  = 2'd0;
               state_next = IDLE;
            end
         endcase
      end
   end

   assign d0          = d0_reg;
   assign d1          = d1_reg;
   assign d2          = d2_reg;
   assign frame_valid = frame_valid_reg;
   assign sync_err    = sync_err_reg;
   assign slot        = slot_reg;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed vector table for the framing corner cases, a
// streaming sequence, then randomized traffic against a queue-based model.
module tb_tdm_demux;

   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         sync;
   logic [W-1:0] din;
   logic [W-1:0] d0, d1, d2;
   logic         frame_valid;
   logic         sync_err;
   logic [1:0]   slot;

   int n_tests = 0;
   int n_fail  = 0;

   tdm_demux #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .sync        (sync),
      .din         (din),
      .d0          (d0),
      .d1          (d1),
      .d2          (d2),
      .frame_valid (frame_valid),
      .sync_err    (sync_err),
      .slot        (slot)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (frame-level view) ----------------
   bit           m_synced = 0;
   logic [W-1:0] m_part[$];
   logic [W-1:0] m_d0 = '0, m_d1 = '0, m_d2 = '0;
   bit           m_fv = 0, m_err = 0;

   task automatic model_step(input bit r, input bit e, input bit s, input logic [W-1:0] x);
      m_fv  = 0;
      m_err = 0;
      if (r) begin
         m_synced = 0;
         m_part.delete();
         m_d0 = '0; m_d1 = '0; m_d2 = '0;
      end else if (e) begin
         if (s) begin
            if (m_synced && m_part.size() != 0) m_err = 1;
            m_synced = 1;
            m_part.delete();
            m_part.push_back(x);
         end else if (m_synced) begin
            if (m_part.size() == 0) begin
               m_err    = 1;
               m_synced = 0;
            end else begin
               m_part.push_back(x);
               if (m_part.size() == 3) begin
                  m_d0 = m_part[0]; m_d1 = m_part[1]; m_d2 = m_part[2];
                  m_fv = 1;
                  m_part.delete();
               end
            end
         end
      end
   endtask

   // ---------------- drive / compare helpers ----------------
   task automatic step(input bit r, input bit e, input bit s, input logic [W-1:0] x);
      rst = r; en = e; sync = s; din = x;
      model_step(r, e, s, x);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [W-1:0] e0, input logic [W-1:0] e1,
                        input logic [W-1:0] e2, input logic efv, input logic eerr,
                        input logic [1:0] eslot);
      n_tests++;
      if ({d0, d1, d2, frame_valid, sync_err, slot} !== {e0, e1, e2, efv, eerr, eslot}) begin
         n_fail++;
         $display("FAIL %s: got d0=%0d d1=%0d d2=%0d fv=%0b err=%0b slot=%0d, expected d0=%0d d1=%0d d2=%0d fv=%0b err=%0b slot=%0d",
                  name, d0, d1, d2, frame_valid, sync_err, slot, e0, e1, e2, efv, eerr, eslot);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit           r, e, s;
      logic [W-1:0] x;
      logic [W-1:0] e0, e1, e2;
      bit           efv, eerr;
      logic [1:0]   eslot;
      string        name;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string nm, input bit r, input bit e, input bit s, input int x,
                      input int e0, input int e1, input int e2, input bit efv,
                      input bit eerr, input int eslot);
      vec_t v;
      v.name = nm; v.r = r; v.e = e; v.s = s; v.x = W'(x);
      v.e0 = W'(e0); v.e1 = W'(e1); v.e2 = W'(e2);
      v.efv = efv; v.eerr = eerr; v.eslot = 2'(eslot);
      tbl.push_back(v);
   endtask

   initial begin
      logic [W-1:0] fw[3];
      logic [W-1:0] p0, p1, p2;
      int           cyc;
      bit           r, e, s;
      logic [W-1:0] x;

      rst = 1'b1; en = 1'b0; sync = 1'b0; din = '0;

      //    name        rst en sy din   d0 d1 d2 fv er slot
      add("reset",       1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
      add("basic_s0",    0, 1, 1, 1,   0, 0, 0, 0, 0, 1);
      add("basic_s1",    0, 1, 0, 2,   0, 0, 0, 0, 0, 2);
      add("basic_commit",0, 1, 0, 3,   1, 2, 3, 1, 0, 0);
      add("basic_hold",  0, 0, 1, 0,   1, 2, 3, 0, 0, 0);
      add("short_a",     0, 1, 1, 2,   1, 2, 3, 0, 0, 1);
      add("short_err",   0, 1, 1, 3,   1, 2, 3, 0, 1, 1);
      add("short_c",     0, 1, 0, 0,   1, 2, 3, 0, 0, 2);
      add("short_commit",0, 1, 0, 2,   3, 0, 2, 1, 0, 0);
      add("miss_err",    0, 1, 0, 1,   3, 0, 2, 0, 1, 0);
      add("miss_idle",   0, 1, 0, 3,   3, 0, 2, 0, 0, 0);
      add("gap_a",       0, 1, 1, 2,   3, 0, 2, 0, 0, 1);
      add("gap_1",       0, 0, 1, 1,   3, 0, 2, 0, 0, 1);
      add("gap_2",       0, 0, 0, 3,   3, 0, 2, 0, 0, 1);
      add("gap_3",       0, 0, 1, 0,   3, 0, 2, 0, 0, 1);
      add("gap_b",       0, 1, 0, 1,   3, 0, 2, 0, 0, 2);
      add("gap_4",       0, 0, 1, 2,   3, 0, 2, 0, 0, 2);
      add("gap_commit",  0, 1, 0, 3,   2, 1, 3, 1, 0, 0);
      add("mrst_s0",     0, 1, 1, 1,   2, 1, 3, 0, 0, 1);
      add("mrst_s1",     0, 1, 0, 2,   2, 1, 3, 0, 0, 2);
      add("mrst_rst",    1, 1, 1, 3,   0, 0, 0, 0, 0, 0);
      add("mrst_nosync", 0, 1, 0, 3,   0, 0, 0, 0, 0, 0);
      add("mrst_f0",     0, 1, 1, 1,   0, 0, 0, 0, 0, 1);
      add("mrst_f1",     0, 1, 0, 2,   0, 0, 0, 0, 0, 2);
      add("mrst_commit", 0, 1, 0, 3,   1, 2, 3, 1, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].x);
         check(tbl[i].name, tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].efv, tbl[i].eerr, tbl[i].eslot);
      end

      // ---------------- streaming: 4 back-to-back frames ----------------
      step(1'b1, 1'b0, 1'b0, '0);
      check("stream_reset", '0, '0, '0, 1'b0, 1'b0, 2'd0);
      p0 = '0; p1 = '0; p2 = '0;
      cyc = 0;
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < 3; k++) begin
            fw[k] = W'($urandom);
            step(1'b0, 1'b1, (k == 0), fw[k]);
            cyc++;
            if (cyc % 3 == 0) begin
               p0 = fw[0]; p1 = fw[1]; p2 = fw[2];
            end
            check($sformatf("stream_c%0d", cyc), p0, p1, p2, (cyc % 3 == 0), 1'b0, 2'(cyc % 3));
         end
      end

      // ---------------- randomized traffic vs. model ----------------
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 59) == 0);
         e = ($urandom_range(0, 3) != 0);
         if (m_part.size() == 0) s = ($urandom_range(0, 9) != 0);
         else                    s = ($urandom_range(0, 9) == 0);
         x = W'($urandom);
         step(r, e, s, x);
         check($sformatf("rand_%0d", i), m_d0, m_d1, m_d2, m_fv, m_err, 2'(m_part.size()));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, meaning the width of each data slot.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: din/sync qualifier; when low, din and sync are ignored.
REQ-005 The block SHALL have port sync, input, 1 bit: marks the current din word as slot 0 of a frame.
REQ-006 The block SHALL have port din, input, WIDTH bits: time-multiplexed slot data, 3 slots per frame.
REQ-007 The block SHALL have ports d0, d1 and d2, each output, WIDTH bits, registered: last complete frame's slots 0, 1 and 2.
REQ-008 The block SHALL have port frame_valid, output, 1 bit, registered: one-cycle pulse when d0..d2 carry a newly committed frame.
REQ-009 The block SHALL have port sync_err, output, 1 bit, registered: one-cycle pulse on a framing violation.
REQ-010 The block SHALL have port slot, output, 2 bits, registered: index of the next slot expected (0..2).

Function
REQ-011 The block SHALL implement the inverse of a 3:1 selector: it SHALL demultiplex a serial slot stream into three parallel registered words.
REQ-012 The block SHALL have exactly two states, IDLE (unsynchronised) and RUN (synchronised).
REQ-013 With en low, the block SHALL hold all state and outputs, and frame_valid and sync_err SHALL be 0.
REQ-014 In IDLE, en&&!sync SHALL be discarded, with slot held at 0 and no error.
REQ-015 In IDLE, en&&sync SHALL capture din into shadow slot 0, set slot to 1 and enter RUN.
REQ-016 In RUN with slot==0, en&&sync SHALL capture din into shadow slot 0 and set slot to 1.
REQ-017 In RUN with slot==1, en&&!sync SHALL capture din into shadow slot 1 and set slot to 2.
REQ-018 In RUN with slot==2, en&&!sync SHALL, on the same edge, load d0<=shadow0, d1<=shadow1, d2<=din, set frame_valid for the following cycle only and wrap slot to 0.
REQ-019 Latency SHALL be as follows: d0..d2 and frame_valid SHALL become visible in the cycle after the edge capturing slot 2.
REQ-020 In RUN with slot==1 or 2, en&&sync (short frame) SHALL pulse sync_err, discard the partial shadow, capture din as slot 0, set slot to 1 and keep d0..d2 unchanged.
REQ-021 In RUN with slot==0, en&&!sync (missing sync) SHALL pulse sync_err, discard din, enter IDLE and keep slot at 0.
REQ-022 Back-to-back frames (en continuously high, sync every 3rd word) SHALL produce frame_valid every 3 cycles with no gaps.
REQ-023 en gaps inside a frame SHALL stretch the frame without error.
REQ-024 d0..d2 SHALL change only on a frame commit or on reset; they SHALL never expose partial frames.
REQ-025 All data paths SHALL be WIDTH bits with no truncation or extension.

Reset
REQ-026 With rst high at a clock edge, the block SHALL set state to IDLE, slot to 0, d0/d1/d2 to 0, frame_valid to 0, sync_err to 0 and shadow registers to 0.
REQ-027 rst SHALL take priority over en/sync in the same cycle.
REQ-028 rst asserted mid-frame SHALL discard the partial frame, and no frame_valid SHALL follow.
REQ-029 After rst deassertion, the first commit SHALL require a fresh sync.

Verification
REQ-030 The bench SHALL cover a basic frame: WIDTH=2, words 2'b01(sync),2'b10,2'b11 with en=1 -> one cycle after the 3rd edge d0=01,d1=10,d2=11, frame_valid=1 for exactly 1 cycle, slot=0.
REQ-031 The bench SHALL cover streaming: 4 consecutive frames with en=1 -> frame_valid high on cycles 3,6,9,12 after the first sync, and outputs match each frame.
REQ-032 The bench SHALL cover a short frame: sync,A, then sync,B,C,D -> sync_err pulse at the 2nd sync, then d0=B,d1=C,d2=D with a single frame_valid; the prior d0..d2 are held until then.
REQ-033 The bench SHALL cover a missing sync: a complete frame followed by an unsynced word -> sync_err pulse, state IDLE, d0..d2 unchanged, and no commit until the next sync.
REQ-034 The bench SHALL cover en gaps: sync,A,(en=0 x3),B,(en=0),C -> commit of A,B,C, no sync_err, and slot holds during the gaps.
REQ-035 The bench SHALL cover mid-frame reset: sync,A,B then rst=1 with en=1,sync=1 -> all outputs 0, slot=0, and no frame_valid; after release, a full frame is needed for a commit.
